// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// one-bit borrow/difference rule.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Returns {borrow_out, difference} for a single bit position.
   function automatic logic [1:0] sub_bit(input logic i_a, input logic i_b, input logic i_bin);
      logic w_d;
      logic w_bout;
      w_d    = i_a ^ i_b ^ i_bin;
      w_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
      return {w_bout, w_d};
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor
   import serial_sub_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign {o_bout, o_d} = sub_bit(i_a, i_b, i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output state_t           o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready is high only in IDLE, out_valid only in DONE, and
   // result fields stay frozen while out_valid waits for out_ready.

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_bout;
   logic             r_ovf;
   logic             w_accept;
   logic             w_run;
   logic             w_d;
   logic             w_bout;

   full_subtractor u_fs (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_RUN;
         end
         S_RUN: begin
            if (r_cnt == LAST) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = in_valid & in_ready;
   assign w_run    = (r_state == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a_sh   <= a;
         r_b_sh   <= b;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= bin;
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
      end else if (w_run) begin
         r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
         r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
         r_diff   <= {w_d, r_diff[WIDTH-1:1]};
         r_cnt    <= r_cnt + 1'b1;
         r_borrow <= w_bout;
         // The bit processed last is the result MSB, so w_d is diff's sign.
         if (r_cnt == LAST) begin
            r_bout <= w_bout;
            r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
         end
      end
   end

   assign diff        = r_diff;
   assign bout        = r_bout;
   assign ovf         = r_ovf;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake/boundary cases plus
// exhaustive and random operands checked against an arithmetic model.
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   state_t       dbg_state;

   int           total = 0;
   int           bad = 0;
   logic [W+1:0] exp_q[$];
   bit           rand_bp = 1'b0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .bin         (bin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .diff        (diff),
      .bout        (bout),
      .ovf         (ovf),
      .o_dbg_state (dbg_state)
   );

   // Reference: {diff, bout, ovf} from integer arithmetic.
   function automatic logic [W+1:0] model(input int ia, input int ib, input int ibin);
      int           u, sa, sb, s, sum;
      logic [W-1:0] d;
      logic         bo, ov;
      u   = ia - ib - ibin;
      d   = u[W-1:0];
      sum = ia + ((~ib) & ((1 << W) - 1)) + (1 - ibin);
      bo  = ((sum >> W) & 1) == 0;
      sa  = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
      sb  = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
      s   = sa - sb - ibin;
      ov  = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
      return {d, bo, ov};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input int ia, input int ib, input int ibin);
      int t;
      t        = 0;
      a        = ia[W-1:0];
      b        = ib[W-1:0];
      bin      = ibin[0];
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 100) break;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=%0b expected 1 within 100 cycles", in_ready);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(ia, ib, ibin));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts falling edges until out_valid is seen; returns at that edge.
   task automatic wait_valid(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (out_valid) break;
         if (n > 100) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: out_valid=%0b expected 1 within 100 cycles", out_valid);
            break;
         end
      end
   endtask

   task automatic run_const(input int ia, input int ib, input int ibin,
                            input int ed, input int eb, input int eo, input string name);
      int n;
      send(ia, ib, ibin);
      wait_valid(n);
      chk({name, "_diff"}, diff, ed);
      chk({name, "_bout"}, bout, eb);
      chk({name, "_ovf"},  ovf,  eo);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completed result handshake pops one expectation.
   initial begin
      logic [W+1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got diff=%0h bout=%0b ovf=%0b with nothing expected",
                        diff, bout, ovf);
            end else begin
               e = exp_q.pop_front();
               chk("result", {diff, bout, ovf}, e);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff",      diff,      0);
      chk("rst_bout",      bout,      0);
      chk("rst_ovf",       ovf,       0);
      chk("rst_state",     dbg_state, S_IDLE);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-RUN on 1111 - 0001 aborts the job.
      out_ready = 1'b1;
      a = 4'hF; b = 4'h1; bin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", in_ready, 1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_state_run", dbg_state, S_RUN);
      rst_n = 1'b0;
      #2;
      chk("abort_out_valid_in_rst", out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("abort_no_valid", cnt,      0);
      chk("abort_in_ready2", in_ready, 1);
      chk("abort_diff",     diff,     0);
      chk("abort_bout",     bout,     0);
      chk("abort_ovf",      ovf,      0);
      @(posedge clk); #1;

      // Basic case with latency measurement: valid appears WIDTH+1 falling
      // edges after the accept edge.
      send(5, 3, 0);
      wait_valid(n);
      chk("latency",    n,    W + 1);
      chk("basic_diff", diff, 4'b0010);
      chk("basic_bout", bout, 0);
      chk("basic_ovf",  ovf,  0);
      @(posedge clk); #1;

      run_const(3, 5, 0, 4'b1110, 1, 0, "borrow");
      run_const(0, 0, 1, 4'b1111, 1, 0, "bin_only");
      run_const(8, 1, 0, 4'b0111, 0, 1, "ovf_neg");
      run_const(7, 15, 0, 4'b1000, 1, 1, "ovf_pos");

      // Backpressure, ignored operands during RUN, pending accept after DONE.
      out_ready = 1'b0;
      send(8, 1, 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom);
         b = W'($urandom);
         bin = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("run_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      a = 4'h7; b = 4'hF; bin = 1'b0; in_valid = 1'b1;
      wait_valid(n);
      for (int i = 0; i < 3; i++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready",  in_ready,  0);
         chk("bp_result",    {diff, bout, ovf}, {4'b0111, 1'b0, 1'b1});
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("hs_out_valid", out_valid, 1);
      @(posedge clk); #1;
      exp_q.push_back(model(7, 15, 0));
      @(negedge clk);
      chk("idle_in_ready",  in_ready,  1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_diff_hold", diff,      4'b0111);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("pending_accepted", dbg_state, S_RUN);
      chk("pending_diff_clr", diff,      0);
      wait_valid(n);
      @(posedge clk); #1;

      // Exhaustive back-to-back.
      for (int ia = 0; ia < (1 << W); ia++)
         for (int ib = 0; ib < (1 << W); ib++)
            for (int ibin = 0; ibin < 2; ibin++)
               send(ia, ib, ibin);

      // Random operands with random consumer backpressure.
      rand_bp = 1'b1;
      repeat (150) send(int'($urandom_range(0, (1 << W) - 1)),
                        int'($urandom_range(0, (1 << W) - 1)),
                        int'($urandom_range(0, 1)));
      rand_bp = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      while (exp_q.size() != 0 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: the inverse-direction companion to the nbitadder ripple adder.
- Computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first.
- Accepts operands and returns results over valid/ready handshakes, so it drops into streaming datapaths where area matters more than latency.
- Results must match the combinational adder identity: a - b - bin == a + ~b + ~bin (mod 2^WIDTH), with bout == ~cout.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend (unsigned; also treated as two's complement for ovf).
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result fields valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, mod 2^WIDTH.
- bout  output  1  borrow-out: 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, internal shift registers, borrow and counter cleared.
- Reset mid-operation aborts immediately: the partial result is discarded and no out_valid pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on an edge where in_valid & in_ready.
    - Load a_sh=a, b_sh=b, borrow=bin, cnt=0.
    - Capture a[MSB] and b[MSB] for ovf.
    - Clear diff.
  - RUN: each edge processes bit cnt.
    - d = a_sh[0]^b_sh[0]^borrow.
    - borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
    - diff shifts right with d entering at MSB; a_sh and b_sh shift right; cnt increments.
  - RUN -> DONE on the edge processing bit WIDTH-1 (cnt==WIDTH-1).
    - bout <= final borrow; ovf computed from captured signs and the final d.
  - DONE -> IDLE on an edge where out_valid & out_ready.
- Latency: accept edge at cycle k; out_valid is high from cycle k+WIDTH+1 (WIDTH RUN cycles). Throughput: one operation per WIDTH+2 cycles with out_ready held high.
- in_ready = (state==IDLE). in_valid is ignored outside IDLE; operands change during RUN do not affect the result.
- out_valid = (state==DONE). diff, bout and ovf hold stable while out_valid=1 & out_ready=0 (backpressure, unbounded).
- diff, bout and ovf remain at the last result after the handshake until the next accept clears diff. Consumers qualify with out_valid.
- Simultaneous out handshake and new in_valid: new operands are not accepted in the same cycle (in_ready=0 in DONE). They are accepted the next cycle in IDLE.
- Out-of-range cnt is impossible: cnt width is $clog2(WIDTH), and it resets to 0 on every accept.

Decomposition:
- Package serial_sub_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - borrow/difference function for one bit, shared with any future serial adder.
- Sub-module full_subtractor (1-bit: a, b, bin -> d, bout), pure combinational, instantiated once in the RUN datapath.
- Top holds the FSM, counter, shift registers and handshake.

Test Plan:
- Reset: assert rst_n=0 mid-RUN on a 4'b1111-4'b0001 job -> out_valid stays 0. After release: in_ready=1, diff=0, bout=0, ovf=0.
- Basic (WIDTH=4): a=0101, b=0011, bin=0 -> after 4 RUN cycles out_valid=1, diff=0010, bout=0, ovf=0. Check out_valid rises exactly at cycle k+5.
- Borrow: a=0011, b=0101, bin=0 -> diff=1110, bout=1, ovf=0. Also a=0000, b=0000, bin=1 -> diff=1111, bout=1.
- Signed overflow: a=1000, b=0001, bin=0 -> diff=0111, bout=0, ovf=1. Also a=0111, b=1111 -> diff=1000, bout=1, ovf=1.
- Backpressure/handshake:
  - Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0.
  - Toggle in_valid with new operands during RUN -> ignored.
  - Raise out_ready -> next cycle IDLE, and a pending in_valid is accepted one cycle later.
- Exhaustive cross-check: all 512 (a, b, bin) combinations, back-to-back with out_ready=1 -> diff == (a-b-bin) mod 16, bout == ~cout of nbitadder(a, ~b, ~bin).
